// File: rtl/fir_out_requant_decim_if.sv
// fir_out_requant_decim_if: valid/ready sample stream from the requantiser to its sink
//   out_data  : signed head-of-FIFO sample
//   out_valid : out_data holds a sample
//   out_ready : sink accepts out_data this cycle
interface fir_out_requant_decim_if #(
    parameter int OUT_W = 16
) ();
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_out_requant_decim.sv
// fir_out_requant_decim: decimate, round and saturate full-precision FIR output into a show-ahead FIFO
//   clk, reset  : clock, asynchronous active-high reset
//   clk_enable  : FIR sample strobe; filter_in is taken when high
//   filter_in   : signed IN_W FIR output
//   clr_status  : pulse clearing sat_flag, ovf_flag and drop_count
//   out_if      : valid/ready output stream (master side)
//   fill_level  : FIFO occupancy
//   sat_flag    : sticky, a stored sample was clipped
//   ovf_flag    : sticky, a sample was dropped on a full FIFO
//   drop_count  : dropped samples, saturating at 255
module fir_out_requant_decim #(
    parameter int IN_W       = 33,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 15,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clk_enable,
    input  logic signed [IN_W-1:0]            filter_in,
    input  logic                              clr_status,
    fir_out_requant_decim_if.master           out_if,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill_level,
    output logic                              sat_flag,
    output logic                              ovf_flag,
    output logic [7:0]                        drop_count
);
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int RW = IN_W + 1 - FRAC_SHIFT;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(DECIM - 1);
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (FRAC_SHIFT - 1);
    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W - 1){1'b0}}};

    logic [PW-1:0]        r_phase;
    logic signed [RW-1:0] r_s1;
    logic                 r_s1_valid;
    logic [OUT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic                 r_sat;
    logic                 r_ovf;
    logic [7:0]           r_drops;

    logic                 w_capture;
    logic signed [IN_W:0] w_sum;
    logic                 w_ovr;
    logic [OUT_W-1:0]     w_s2;
    logic                 w_valid;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    // Extra sign bit keeps the rounding add from wrapping at the positive extreme.
    assign w_capture = clk_enable && (r_phase == '0);
    assign w_sum     = {filter_in[IN_W-1], filter_in} + HALF;
    // Out of range when the bits above the output sign bit disagree with it.
    assign w_ovr     = !(&r_s1[RW-1:OUT_W-1]) && (|r_s1[RW-1:OUT_W-1]);
    assign w_s2      = w_ovr ? (r_s1[RW-1] ? MIN_V : MAX_V) : r_s1[OUT_W-1:0];
    assign w_valid   = r_count != '0;
    assign w_full    = r_count == FULL;
    assign w_pop     = w_valid && out_if.out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign w_push    = r_s1_valid && (!w_full || w_pop);
    assign w_drop    = r_s1_valid && w_full && !w_pop;

    assign out_if.out_data  = r_mem[r_rd_ptr];
    assign out_if.out_valid = w_valid;
    assign fill_level       = r_count;
    assign sat_flag         = r_sat;
    assign ovf_flag         = r_ovf;
    assign drop_count       = r_drops;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase    <= '0;
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (clk_enable) r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
            if (w_capture) r_s1 <= RW'(w_sum >>> FRAC_SHIFT);
            r_s1_valid <= w_capture;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_mem[r_wr_ptr] <= w_s2;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Set events take priority over a coincident clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat   <= 1'b0;
            r_ovf   <= 1'b0;
            r_drops <= '0;
        end else begin
            r_sat   <= (w_push && w_ovr) ? 1'b1 : clr_status ? 1'b0 : r_sat;
            r_ovf   <= w_drop ? 1'b1 : clr_status ? 1'b0 : r_ovf;
            r_drops <= w_drop ? (clr_status ? 8'd1 : r_drops + 8'(r_drops != 8'hFF))
                              : clr_status ? 8'd0 : r_drops;
        end
    end
endmodule

// File: tb/tb_fir_out_requant_decim.sv
// tb_fir_out_requant_decim: directed checks of rounding, saturation, decimation, FIFO and status
module tb_fir_out_requant_decim;
    localparam logic signed [32:0] P31 = 33'h0_8000_0000;
    localparam logic signed [32:0] N32 = 33'h1_0000_0000;

    logic clk = 0;
    logic reset = 0;
    logic clk_enable = 0;
    logic clr_status = 0;
    logic signed [32:0] filter_in = '0;
    logic [2:0] fill1, fill4;
    logic sat1, ovf1, sat4, ovf4;
    logic [7:0] drop1, drop4;
    int total = 0;
    int bad = 0;
    logic [15:0] q4[$];

    logic signed [32:0] rv[5] = '{33'sd32768, 33'sd16384, 33'sd16383, -33'sd16384, -33'sd16385};
    logic [15:0] re[5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF};
    logic [15:0] de[3] = '{16'd0, 16'd4, 16'd8};
    logic [15:0] fe[4] = '{16'd2, 16'd3, 16'd4, 16'd9};

    fir_out_requant_decim_if #(.OUT_W(16)) if1 ();
    fir_out_requant_decim_if #(.OUT_W(16)) if4 ();

    fir_out_requant_decim #(.DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .filter_in(filter_in),
        .clr_status(clr_status), .out_if(if1), .fill_level(fill1),
        .sat_flag(sat1), .ovf_flag(ovf1), .drop_count(drop1));

    fir_out_requant_decim #(.DECIM(4)) dut4 (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .filter_in(filter_in),
        .clr_status(clr_status), .out_if(if4), .fill_level(fill4),
        .sat_flag(sat4), .ovf_flag(ovf4), .drop_count(drop4));

    always #5 clk = ~clk;

    task tick;
        @(posedge clk);
        #1;
        if (if4.out_valid && if4.out_ready) q4.push_back(if4.out_data);
    endtask

    task drive(input logic signed [32:0] v);
        clk_enable = 1;
        filter_in = v;
        tick();
        clk_enable = 0;
    endtask

    task do_reset;
        reset = 1;
        #2;
        reset = 0;
        tick();
    endtask

    task test_reset;
        if1.out_ready = 0;
        if4.out_ready = 1;
        #1;
        reset = 1;
        #2;
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h exp=0", if1.out_valid); end
        total++; if (if1.out_data !== 16'h0) begin bad++; $display("FAIL rst_data got=%0h exp=0", if1.out_data); end
        total++; if (fill1 !== 3'd0) begin bad++; $display("FAIL rst_fill got=%0d exp=0", fill1); end
        total++; if ({sat1, ovf1, drop1} !== 10'd0) begin bad++; $display("FAIL rst_status got=%0h exp=0", {sat1, ovf1, drop1}); end
        tick();
        reset = 0;
        tick();
    endtask

    task test_round;
        if1.out_ready = 1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                clk_enable = 1;
                filter_in = rv[i];
            end else clk_enable = 0;
            tick();
            if (i >= 1) begin
                total++;
                if ({if1.out_valid, if1.out_data} !== {1'b1, re[i-1]})
                    begin bad++; $display("FAIL round[%0d] got=%0h/%0h exp=1/%0h", i - 1, if1.out_valid, if1.out_data, re[i-1]); end
            end
        end
        tick();
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL round_drain got=%0h exp=0", if1.out_valid); end
    endtask

    task test_sat;
        if1.out_ready = 1;
        drive(P31);
        tick();
        total++; if ({if1.out_valid, if1.out_data} !== {1'b1, 16'h7FFF}) begin bad++; $display("FAIL sat_pos got=%0h exp=17fff", {if1.out_valid, if1.out_data}); end
        total++; if (sat1 !== 1'b1) begin bad++; $display("FAIL sat_flag_pos got=%0h exp=1", sat1); end
        tick();
        drive(N32);
        tick();
        total++; if ({if1.out_valid, if1.out_data} !== {1'b1, 16'h8000}) begin bad++; $display("FAIL sat_neg got=%0h exp=18000", {if1.out_valid, if1.out_data}); end
        clr_status = 1;
        tick();
        clr_status = 0;
        total++; if (sat1 !== 1'b0) begin bad++; $display("FAIL sat_clr got=%0h exp=0", sat1); end
        drive(P31);
        clr_status = 1;
        tick();
        clr_status = 0;
        total++; if (sat1 !== 1'b1) begin bad++; $display("FAIL sat_clr_race got=%0h exp=1", sat1); end
        tick();
    endtask

    task test_decim;
        do_reset();
        if4.out_ready = 1;
        q4.delete();
        for (int k = 0; k < 12; k++) drive(33'(k * 32768));
        repeat (4) tick();
        total++; if (q4.size() != 3) begin bad++; $display("FAIL decim_cnt got=%0d exp=3", q4.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= q4.size() || q4[i] !== de[i]) begin bad++; $display("FAIL decim[%0d] got=%0h exp=%0h", i, (i < q4.size()) ? q4[i] : 16'hxxxx, de[i]); end
        end
        q4.delete();
        for (int k = 0; k < 12; k++) begin
            drive(33'(k * 32768));
            filter_in = 33'h0_7FFF_0000;
            tick();
        end
        repeat (4) tick();
        total++; if (q4.size() != 3) begin bad++; $display("FAIL decim_gap_cnt got=%0d exp=3", q4.size()); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (i >= q4.size() || q4[i] !== de[i]) begin bad++; $display("FAIL decim_gap[%0d] got=%0h exp=%0h", i, (i < q4.size()) ? q4[i] : 16'hxxxx, de[i]); end
        end
    endtask

    task test_backpressure;
        do_reset();
        if1.out_ready = 0;
        for (int v = 1; v <= 6; v++) drive(33'(v * 32768));
        tick();
        tick();
        total++; if (fill1 !== 3'd4) begin bad++; $display("FAIL bp_fill got=%0d exp=4", fill1); end
        total++; if (drop1 !== 8'd2) begin bad++; $display("FAIL bp_drops got=%0d exp=2", drop1); end
        total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%0h exp=1", ovf1); end
        total++; if ({if1.out_valid, if1.out_data} !== {1'b1, 16'd1}) begin bad++; $display("FAIL bp_head got=%0h exp=10001", {if1.out_valid, if1.out_data}); end
        tick();
        total++; if (if1.out_data !== 16'd1) begin bad++; $display("FAIL bp_stable got=%0h exp=1", if1.out_data); end
        if1.out_ready = 1;
        for (int j = 0; j < 4; j++) begin
            total++;
            if ({if1.out_valid, if1.out_data} !== {1'b1, 16'(j + 1)}) begin bad++; $display("FAIL bp_drain[%0d] got=%0h exp=%0h", j, {if1.out_valid, if1.out_data}, {1'b1, 16'(j + 1)}); end
            tick();
        end
        total++; if ({if1.out_valid, fill1} !== 4'd0) begin bad++; $display("FAIL bp_empty got=%0h exp=0", {if1.out_valid, fill1}); end
    endtask

    task test_full_pushpop;
        do_reset();
        if1.out_ready = 0;
        for (int v = 1; v <= 4; v++) drive(33'(v * 32768));
        drive(33'(9 * 32768));
        if1.out_ready = 1;
        tick();
        total++; if (fill1 !== 3'd4) begin bad++; $display("FAIL pp_fill got=%0d exp=4", fill1); end
        total++; if ({ovf1, drop1} !== 9'd0) begin bad++; $display("FAIL pp_nodrop got=%0h exp=0", {ovf1, drop1}); end
        for (int j = 0; j < 4; j++) begin
            total++;
            if ({if1.out_valid, if1.out_data} !== {1'b1, fe[j]}) begin bad++; $display("FAIL pp_out[%0d] got=%0h exp=%0h", j, {if1.out_valid, if1.out_data}, {1'b1, fe[j]}); end
            tick();
        end
        total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL pp_empty got=%0h exp=0", if1.out_valid); end
    endtask

    task test_drop_sat;
        do_reset();
        if1.out_ready = 0;
        repeat (260) drive(33'sd32768);
        tick();
        total++; if (drop1 !== 8'd255) begin bad++; $display("FAIL drop_sat got=%0d exp=255", drop1); end
        drive(33'sd32768);
        clr_status = 1;
        tick();
        clr_status = 0;
        total++; if ({ovf1, drop1} !== {1'b1, 8'd1}) begin bad++; $display("FAIL drop_clr_race got=%0h exp=101", {ovf1, drop1}); end
        clr_status = 1;
        tick();
        clr_status = 0;
        total++; if ({ovf1, drop1} !== 9'd0) begin bad++; $display("FAIL drop_clr got=%0h exp=0", {ovf1, drop1}); end
    endtask

    task test_reset_mid;
        do_reset();
        if1.out_ready = 0;
        drive(P31);
        drive(33'sd65536);
        drive(33'sd98304);
        drive(33'sd131072);
        total++; if ({fill1, sat1} !== {3'd3, 1'b1}) begin bad++; $display("FAIL mid_pre got=%0h exp=7", {fill1, sat1}); end
        reset = 1;
        #1;
        total++; if ({if1.out_valid, fill1} !== 4'd0) begin bad++; $display("FAIL mid_fifo got=%0h exp=0", {if1.out_valid, fill1}); end
        total++; if ({sat1, ovf1, drop1} !== 10'd0) begin bad++; $display("FAIL mid_status got=%0h exp=0", {sat1, ovf1, drop1}); end
        #1;
        reset = 0;
        tick();
        tick();
        total++; if (fill1 !== 3'd0) begin bad++; $display("FAIL mid_inflight got=%0d exp=0", fill1); end
        drive(33'sd65536);
        tick();
        total++; if ({if1.out_valid, if1.out_data, fill1} !== {1'b1, 16'd2, 3'd1}) begin bad++; $display("FAIL mid_after got=%0h/%0h/%0d exp=1/2/1", if1.out_valid, if1.out_data, fill1); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_sat();
        test_decim();
        test_backpressure();
        test_full_pushpop();
        test_drop_sat();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
